daq_wb_master: RTL and testbench

Single-transfer Wishbone classic master that executes the bus requests issued by the DAQ state machine. It latches a request from the DAQ request interface (start/address/selection/write/data_wr) and runs one Wishbone cycle. It returns read data and busy status on data_rd and active. A watchdog aborts cycles that the slave never acknowledges.

---
 rtl/daq_wb_master.sv | 134 +++++++++++++
 tb/tb_daq_wb_master.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/daq_wb_master.sv
// Single-transfer Wishbone classic master driven by the DAQ state machine.
// Latches one request, runs one bus cycle, reports done/error, and aborts
// cycles that the slave never answers after TIMEOUT bus cycles.
module daq_wb_master #(
  parameter int dw      = 32,
  parameter int aw      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          start,
  input  logic [aw-1:0] address,
  input  logic [3:0]    selection,
  input  logic          write,
  input  logic [dw-1:0] data_wr,
  output logic [dw-1:0] data_rd,
  output logic          active,
  output logic          done,
  output logic          error,
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic [dw-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUS    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [1:0]    r_state;
  logic [15:0]   r_cnt;
  logic [dw-1:0] r_data_rd;
  logic          r_active;
  logic          r_done;
  logic          r_error;
  logic [aw-1:0] r_adr;
  logic [dw-1:0] r_dat;
  logic [3:0]    r_sel;
  logic          r_we;
  logic          r_cyc;
  logic          r_stb;
  logic          w_abort;

  // Abort on slave error (wins over ack) or when the last allowed bus
  // cycle passes without any response.
  always_comb begin
    w_abort = wb_err_i || (!wb_ack_i && (r_cnt == TO_LAST));
  end

  // Transfer sequencer: request latch, bus cycle, completion pulse.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_data_rd <= '0;
      r_active  <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_sel     <= '0;
      r_we      <= 1'b0;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_adr    <= address;
            r_sel    <= selection;
            r_we     <= write;
            r_dat    <= data_wr;
            r_cyc    <= 1'b1;
            r_stb    <= 1'b1;
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_BUS;
          end
        end
        S_BUS: begin
          if (w_abort) begin
            r_cyc    <= 1'b0;
            r_stb    <= 1'b0;
            r_active <= 1'b0;
            r_done   <= 1'b1;
            r_error  <= 1'b1;
            r_state  <= S_FINISH;
          end else if (wb_ack_i) begin
            r_cyc    <= 1'b0;
            r_stb    <= 1'b0;
            r_active <= 1'b0;
            r_done   <= 1'b1;
            if (!r_we) begin
              r_data_rd <= wb_dat_i;
            end
            r_state  <= S_FINISH;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state  <= S_IDLE;
          r_cyc    <= 1'b0;
          r_stb    <= 1'b0;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign data_rd  = r_data_rd;
  assign active   = r_active;
  assign done     = r_done;
  assign error    = r_error;
  assign wb_adr_o = r_adr;
  assign wb_dat_o = r_dat;
  assign wb_sel_o = r_sel;
  assign wb_we_o  = r_we;
  assign wb_cyc_o = r_cyc;
  assign wb_stb_o = r_stb;

endmodule

// File: tb/tb_daq_wb_master.sv
// Directed self-checking bench for daq_wb_master (TIMEOUT=8).
module tb_daq_wb_master;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic        start;
  logic [31:0] address;
  logic [3:0]  selection;
  logic        write;
  logic [31:0] data_wr;
  logic [31:0] data_rd;
  logic        active;
  logic        done;
  logic        error;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  int n_checks = 0;
  int n_fail   = 0;

  daq_wb_master #(.dw(32), .aw(32), .TIMEOUT(8)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .start(start), .address(address),
    .selection(selection), .write(write), .data_wr(data_wr),
    .data_rd(data_rd), .active(active), .done(done), .error(error),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a, input logic [3:0] s, input logic w, input logic [31:0] d);
    address = a; selection = s; write = w; data_wr = d; start = 1'b1;
  endtask

  int n_bus;
  int n_cyc;
  int n_done;
  int first_cyc;

  initial begin
    wb_rst = 1'b1; start = 1'b0; address = '0; selection = '0; write = 1'b0;
    data_wr = '0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;

    // Reset held with random inputs: everything stays zero
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom); address = $urandom; selection = 4'($urandom);
      write = 1'($urandom); data_wr = $urandom; wb_dat_i = $urandom;
      wb_ack_i = 1'($urandom); wb_err_i = 1'($urandom);
      tick();
    end
    check("rst_data_rd", data_rd, 32'h0);
    check("rst_flags", {26'd0, active, done, error, wb_we_o, wb_cyc_o, wb_stb_o}, 32'h0);
    check("rst_adr", wb_adr_o, 32'h0);
    check("rst_dat_sel", wb_dat_o | {28'd0, wb_sel_o}, 32'h0);

    start = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = '0;
    wb_rst = 1'b0;
    tick();

    // Zero-wait read
    req(32'h0000_0040, 4'hF, 1'b0, 32'h0);
    tick();
    start = 1'b0;
    check("rd_bus_flags", {29'd0, wb_cyc_o, wb_stb_o, active}, 32'h7);
    check("rd_bus_adr", wb_adr_o, 32'h0000_0040);
    check("rd_bus_we_sel", {27'd0, wb_we_o, wb_sel_o}, 32'h0F);
    check("rd_bus_done", {31'd0, done}, 32'h0);
    wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
    tick();
    wb_ack_i = 1'b0; wb_dat_i = 32'h0;
    check("rd_fin_done_err", {30'd0, done, error}, 32'h2);
    check("rd_fin_idle", {29'd0, active, wb_cyc_o, wb_stb_o}, 32'h0);
    check("rd_data", data_rd, 32'hDEAD_BEEF);
    tick();
    check("rd_done_pulse", {31'd0, done}, 32'h0);

    // Write with 3 wait states: 4 strobe cycles
    req(32'h0000_0010, 4'h3, 1'b1, 32'h1234_5678);
    tick();
    start = 1'b0;
    address = 32'hFFFF_FFFF; data_wr = 32'h0; selection = 4'hC; write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("wr_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'h3);
      check("wr_dat", wb_dat_o, 32'h1234_5678);
      check("wr_adr", wb_adr_o, 32'h0000_0010);
      check("wr_we_sel", {27'd0, wb_we_o, wb_sel_o}, 32'h13);
      if (i == 3) wb_ack_i = 1'b1;
      tick();
    end
    wb_ack_i = 1'b0;
    check("wr_fin_done_err", {30'd0, done, error}, 32'h2);
    check("wr_data_rd_kept", data_rd, 32'hDEAD_BEEF);
    check("wr_cyc_low", {31'd0, wb_cyc_o}, 32'h0);
    tick();

    // Simultaneous ack and err on a read: error wins
    req(32'h0000_0020, 4'hF, 1'b0, 32'h0);
    tick();
    start = 1'b0;
    wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'hCAFE_F00D;
    tick();
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 32'h0;
    check("err_done_err", {30'd0, done, error}, 32'h3);
    check("err_data_rd_kept", data_rd, 32'hDEAD_BEEF);
    check("err_cyc_low", {31'd0, wb_cyc_o}, 32'h0);
    tick();
    check("err_pulse", {30'd0, done, error}, 32'h0);

    // Timeout: slave silent, abort after 8 bus cycles
    req(32'h0000_0030, 4'hF, 1'b0, 32'h0);
    tick();
    start = 1'b0;
    n_bus = 0;
    for (int i = 0; i < 20; i++) begin
      if (!wb_cyc_o) break;
      n_bus++;
      tick();
    end
    check("to_bus_cycles", n_bus, 8);
    check("to_done_err", {30'd0, done, error}, 32'h3);
    tick();
    check("to_pulse_once", {30'd0, done, error}, 32'h0);
    req(32'h0000_0044, 4'hF, 1'b0, 32'h0);
    tick();
    start = 1'b0;
    check("to_next_accept", {31'd0, wb_cyc_o}, 32'h1);
    wb_ack_i = 1'b1; wb_dat_i = 32'h0BAD_CAFE;
    tick();
    wb_ack_i = 1'b0; wb_dat_i = 32'h0;
    check("to_next_done", {30'd0, done, error}, 32'h2);
    check("to_next_data", data_rd, 32'h0BAD_CAFE);
    tick();

    // start pulses while active and in FINISH are not queued
    req(32'h0000_0050, 4'h1, 1'b1, 32'hA5A5_A5A5);
    tick();
    start = 1'b1; address = 32'h0000_0060;
    tick();
    tick();
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    check("ign_done", {31'd0, done}, 32'h1);
    start = 1'b0;
    tick();
    tick();
    check("ign_no_extra_cyc", {31'd0, wb_cyc_o}, 32'h0);
    check("ign_adr_kept", wb_adr_o, 32'h0000_0050);

    // Back-to-back: start held high, zero-wait slave
    req(32'h0000_0070, 4'hF, 1'b0, 32'h0);
    wb_ack_i = 1'b1; wb_dat_i = 32'h7777_0000;
    n_cyc = 0; n_done = 0; first_cyc = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (wb_cyc_o) begin
        n_cyc++;
        if (first_cyc < 0) first_cyc = i;
        else check("b2b_spacing", (i - first_cyc) % 3, 0);
      end
      if (done) n_done++;
    end
    start = 1'b0; wb_ack_i = 1'b0;
    check("b2b_cycles", n_cyc, 4);
    check("b2b_done", n_done, 4);
    check("b2b_first", first_cyc, 1);
    tick();
    tick();

    // Reset asserted mid-cycle drops cyc/stb without a clock edge
    req(32'h0000_0080, 4'hF, 1'b0, 32'h0);
    tick();
    start = 1'b0;
    check("mr_cyc_before", {30'd0, wb_cyc_o, wb_stb_o}, 32'h3);
    #2 wb_rst = 1'b1;
    #1;
    check("mr_cyc_async", {29'd0, wb_cyc_o, wb_stb_o, active}, 32'h0);
    #1 wb_rst = 1'b0;
    tick();
    check("mr_no_done", {30'd0, done, error}, 32'h0);
    check("mr_idle", {31'd0, wb_cyc_o}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
